// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared pipeline constants and hazard FSM state encoding
package pipeline_hazard_ctrl_pkg;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN      = 2'b00;
    localparam state_t ST_MEM_WAIT = 2'b01;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    import pipeline_hazard_ctrl_pkg::*;
    logic [REG_AW-1:0] IF_ID_RSaddr_i;
    logic [REG_AW-1:0] IF_ID_RTaddr_i;
    logic [REG_AW-1:0] ID_EX_RTaddr_i;
    logic              ID_EX_MemRead_i;
    logic              branch_taken_i;
    logic              dmem_req_i;
    logic              dmem_ack_i;
    logic              PCWrite_o;
    logic              IF_ID_Write_o;
    logic              IF_ID_Flush_o;
    logic              ID_EX_Bubble_o;
    logic              pipe_hold_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic              err_timeout_o;
    modport master (
        output IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_EX_RTaddr_i, ID_EX_MemRead_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        input  PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o,
               pipe_hold_o, stall_cnt_o, err_timeout_o
    );
    modport slave (
        input  IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_EX_RTaddr_i, ID_EX_MemRead_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        output PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o,
               pipe_hold_o, stall_cnt_o, err_timeout_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cnt.sv
// hazard_cnt: saturating up-counter with clear, used for stall statistics and memory wait timing
module hazard_cnt #(
    parameter int W = 16,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] r_cnt;
    // clear wins over increment; increment stops at LIMIT
    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) r_cnt <= '0;
        else if (inc_i && r_cnt != LIMIT) r_cnt <= r_cnt + 1'b1;
    end
    assign cnt_o = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use bubble, branch flush and memory-wait freeze sequencer
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_err;
    logic              w_in_wait;
    logic              w_mem_stall;
    logic              w_load_use;
    logic              w_freeze;
    logic              w_bubble;
    logic              w_flush;
    logic              w_wait_inc;
    logic              w_wait_clr;
    logic [WAIT_W-1:0] w_wait_cnt;
    logic [CNT_W-1:0]  w_stall_cnt;
    assign w_in_wait   = (r_state == ST_MEM_WAIT);
    assign w_mem_stall = bus.dmem_req_i && !bus.dmem_ack_i;
    assign w_load_use  = bus.ID_EX_MemRead_i && bus.ID_EX_RTaddr_i != ZERO_REG &&
                         (bus.ID_EX_RTaddr_i == bus.IF_ID_RSaddr_i ||
                          bus.ID_EX_RTaddr_i == bus.IF_ID_RTaddr_i);
    // priority freeze > load-use > flush; everything released while in reset
    always_comb begin
        w_freeze    = rst_i && (w_in_wait || w_mem_stall);
        w_bubble    = rst_i && !w_freeze && w_load_use;
        w_flush     = rst_i && !w_freeze && !w_load_use && bus.branch_taken_i;
        w_state_nxt = w_in_wait ? (bus.dmem_ack_i ? ST_RUN : ST_MEM_WAIT)
                                : (w_mem_stall ? ST_MEM_WAIT : ST_RUN);
        w_wait_inc  = w_in_wait ? !bus.dmem_ack_i : w_mem_stall;
        w_wait_clr  = w_in_wait && bus.dmem_ack_i;
    end
    assign bus.PCWrite_o      = !(w_freeze || w_bubble);
    assign bus.IF_ID_Write_o  = !(w_freeze || w_bubble);
    assign bus.ID_EX_Bubble_o = w_bubble;
    assign bus.IF_ID_Flush_o  = w_flush;
    assign bus.pipe_hold_o    = w_freeze;
    assign bus.stall_cnt_o    = w_stall_cnt;
    assign bus.err_timeout_o  = r_err;
    // FSM: only an ack leaves MEM_WAIT; spare encodings behave as RUN
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= ST_RUN;
        else r_state <= w_state_nxt;
    end
    // sticky timeout, raised on the edge where the wait count reaches the limit
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_err <= 1'b0;
        else if (w_wait_inc && !w_wait_clr && w_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) r_err <= 1'b1;
    end
    hazard_cnt #(.W(WAIT_W), .LIMIT(WAIT_W'(MEM_TIMEOUT))) u_wait (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_wait_inc),
        .clr_i (w_wait_clr),
        .cnt_o (w_wait_cnt)
    );
    hazard_cnt #(.W(CNT_W), .LIMIT({CNT_W{1'b1}})) u_stall (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!bus.PCWrite_o),
        .clr_i (1'b0),
        .cnt_o (w_stall_cnt)
    );
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It sits beside the forwarding unit and covers the cases forwarding cannot resolve:
- load-use hazards, handled by a one-cycle bubble;
- taken-branch flush of IF/ID;
- multi-cycle data-memory access, handled by a whole-pipeline freeze.

It drives the write enables of the PC and of every pipeline register, and keeps stall statistics and a memory-timeout error flag.

Parameters:
MEM_TIMEOUT, 64, maximum cycles in MEM_WAIT before err_timeout_o is set.
CNT_W, 16, width of the saturating stall counter.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-low
IF_ID_RSaddr_i  input  5  rs of the instruction in ID
IF_ID_RTaddr_i  input  5  rt of the instruction in ID
ID_EX_RTaddr_i  input  5  destination of the instruction in EX
ID_EX_MemRead_i  input  1  instruction in EX is a load
branch_taken_i  input  1  branch resolved taken in ID this cycle
dmem_req_i  input  1  MEM stage issues a data-memory access this cycle
dmem_ack_i  input  1  data memory completes the access this cycle
PCWrite_o  output  1  PC update enable
IF_ID_Write_o  output  1  IF/ID register load enable
IF_ID_Flush_o  output  1  clear IF/ID to NOP
ID_EX_Bubble_o  output  1  force ID/EX control fields to zero
pipe_hold_o  output  1  freeze ID/EX, EX/MEM and MEM/WB
stall_cnt_o  output  CNT_W  saturating count of stalled cycles
err_timeout_o  output  1  sticky memory-timeout flag

Behaviour:
- Reset: applied on a clock edge when rst_i=0.
  - State becomes RUN; wait_cnt=0; stall_cnt_o=0; err_timeout_o=0.
  - While rst_i=0, the outputs are: PCWrite_o=1, IF_ID_Write_o=1, IF_ID_Flush_o=0, ID_EX_Bubble_o=0, pipe_hold_o=0.
- States: RUN, MEM_WAIT (2-bit encoding, one spare state that decodes to RUN).
- Outputs are combinational from state and current inputs. There is no added latency.
- Hazard conditions:
  - load_use = ID_EX_MemRead_i && ID_EX_RTaddr_i!=0 && (ID_EX_RTaddr_i==IF_ID_RSaddr_i || ID_EX_RTaddr_i==IF_ID_RTaddr_i).
  - mem_stall = dmem_req_i && !dmem_ack_i.
- Priority is freeze > load-use > branch flush.
- RUN state:
  - If mem_stall: PCWrite_o=0, IF_ID_Write_o=0, pipe_hold_o=1, no bubble, no flush. Next state is MEM_WAIT and wait_cnt is set to 1.
  - Else if load_use: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1, IF_ID_Flush_o=0, even if branch_taken_i=1. The branch is re-resolved next cycle.
  - Else if branch_taken_i: IF_ID_Flush_o=1, all enables stay 1.
  - Else all enables are 1 and bubble, flush and hold are 0.
- MEM_WAIT state:
  - Full freeze: PCWrite_o=0, IF_ID_Write_o=0, pipe_hold_o=1. Bubble and flush are suppressed, whatever load_use or branch_taken_i show.
  - On dmem_ack_i=1 the state returns to RUN next cycle. That ack cycle is still frozen.
  - While ack is absent, wait_cnt increments, saturating at MEM_TIMEOUT.
  - When wait_cnt reaches MEM_TIMEOUT, err_timeout_o is set and stays set until reset. The FSM keeps waiting; it does not abort.
  - dmem_req_i is treated as held by MEM while frozen. A deasserted req in MEM_WAIT is ignored; only ack exits.
- stall_cnt_o increments, saturating at all-ones, in every cycle where PCWrite_o=0.
- Reset asserted in MEM_WAIT returns the FSM to RUN on that edge, with no freeze in the following cycle unless mem_stall is present again.
- A simultaneous req and ack in RUN is a single-cycle access: no stall.

Decomposition:
- Shared pipeline package holds:
  - the state typedef (RUN, MEM_WAIT);
  - the register-address width constant (5);
  - the zero-register constant.
- Sub-module hazard_cnt holds the saturating counter used for both stall_cnt_o and wait_cnt. It is parameterised by width and saturation limit, with inc and clear inputs.
- Hazard detection stays inline; it is a few comparators.

Test Plan:
1. Reset (rst_i=0 for 2 cycles, then 1) -> stall_cnt_o=0, err_timeout_o=0, PCWrite_o=1, IF_ID_Write_o=1, all other control outputs 0.
2. ID_EX_MemRead_i=1, ID_EX_RTaddr_i=8, IF_ID_RSaddr_i=8 for one cycle:
   - that cycle: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1;
   - next cycle, with MemRead=0: normal operation;
   - stall_cnt_o=1.
   - Repeat with RTaddr=0 -> no stall.
3. Load-use with rt=9 match and branch_taken_i=1 in the same cycle -> ID_EX_Bubble_o=1, IF_ID_Flush_o=0. Next cycle with branch_taken_i=1 and no hazard -> IF_ID_Flush_o=1.
4. dmem_req_i=1, ack low for 3 cycles then ack=1 -> pipe_hold_o=1 for 4 cycles, RUN on cycle 5, stall_cnt_o=4.
5. MEM_TIMEOUT=4, req with no ack for 6 cycles -> err_timeout_o rises at the 4th wait cycle and stays 1 after ack. A bubble request during the wait is suppressed.
6. Reset asserted during MEM_WAIT -> next cycle the FSM is in RUN, pipe_hold_o=0 (with dmem_req_i=0), wait_cnt=0, err_timeout_o=0.
